apb_master_arbiter: RTL and testbench

//   Shares one APB3 master port among NUM_REQ on-chip requesters (core LSU, debug, DMA).

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_master_arbiter_rr_arbiter.sv | 29 ++
 rtl/apb_master_arbiter.sv | 145 ++++++++++++++
 tb/tb_apb_master_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master arbiter.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_DEFAULT_TIMEOUT = 16;

    // Width of the ACCESS-cycle counter; never narrower than one bit so a
    // disabled timeout still leaves a legal (saturating) register.
    function automatic int cnt_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester after ptr.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant
);

    // Distance of requester i from the slot after ptr; the nearest valid wins.
    always_comb begin
        int best;
        int d;
        best  = N;
        d     = 0;
        grant = '0;
        for (int i = 0; i < N; i++) begin
            d = (i + 2 * N - 1 - int'(ptr)) % N;
            if (req[i] && d < best) best = d;
        end
        for (int i = 0; i < N; i++) begin
            d = (i + 2 * N - 1 - int'(ptr)) % N;
            grant[i] = en && req[i] && (d == best);
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB3 master port with a per-transfer PREADY timeout.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = APB_DEFAULT_TIMEOUT
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    input  logic                          PREADY,
    input  logic [DATA_WIDTH-1:0]         PRDATA
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX = '1;

    apb_state_e             state, next_state;
    logic [PW-1:0]          ptr_q, gidx;
    logic [NUM_REQ-1:0]     grant_q, arb_grant;
    logic [CW-1:0]          cnt_q;
    logic                   arb_en, complete, to_hit;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic                   sel_write;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .en    (arb_en),
        .grant (arb_grant)
    );

    // Payload of the requester being granted this cycle.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_write = req_write[i];
            end
        end
    end

    // Index of the owner of the current transfer, for the rr pointer update.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) gidx = PW'(i);
        end
    end

    // Abort fires on the TIMEOUT-th ACCESS cycle; counter holds ACCESS cycles already spent.
    assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= next_state;
    end

    // Next state and bus/response outputs; PREADY takes priority over abort.
    always_comb begin
        next_state = state;
        arb_en     = 1'b0;
        complete   = 1'b0;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        req_done   = '0;
        rsp_rdata  = '0;
        rsp_err    = 1'b0;
        case (state)
            IDLE: begin
                arb_en = 1'b1;
                if (|req_valid) next_state = SETUP;
            end
            SETUP: begin
                PSEL       = 1'b1;
                next_state = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    complete  = 1'b1;
                    req_done  = grant_q;
                    rsp_rdata = PRDATA;
                end else if (to_hit) begin
                    complete = 1'b1;
                    req_done = grant_q;
                    rsp_err  = 1'b1;
                end
                if (complete) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Latch payload and owner at the grant edge; held through completion and IDLE.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            PADDR   <= '0;
            PWDATA  <= '0;
            PWRITE  <= 1'b0;
            grant_q <= '0;
        end else if (|arb_grant) begin
            PADDR   <= sel_addr;
            PWDATA  <= sel_wdata;
            PWRITE  <= sel_write;
            grant_q <= arb_grant;
        end
    end

    // Pointer moves to the last owner only on completion, so reset leaves req 0 first.
    always_ff @(posedge PCLK) begin
        if (PRESET)        ptr_q <= PW'(NUM_REQ - 1);
        else if (complete) ptr_q <= gidx;
    end

    // ACCESS-cycle counter, saturating so a disabled timeout never wraps.
    always_ff @(posedge PCLK) begin
        if (PRESET)                                           cnt_q <= '0;
        else if (state == SETUP)                              cnt_q <= '0;
        else if (state == ACCESS && !PREADY && cnt_q != CNT_MAX) cnt_q <= cnt_q + CW'(1);
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter (NUM_REQ=2, TIMEOUT=4).
module tb_apb_master_arbiter;

    logic        PCLK, PRESET;
    logic [1:0]  req_valid, req_write, req_done;
    logic [63:0] req_addr, req_wdata;
    logic [31:0] rsp_rdata, PADDR, PWDATA, PRDATA;
    logic        rsp_err, PSEL, PENABLE, PWRITE, PREADY;

    int vectors = 0;
    int miscompares = 0;

    apb_master_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic next_cycle();
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge PCLK);
        vectors++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin
            miscompares++; $display("FAIL reset_ctl: got %b want 000", {PSEL, PENABLE, PWRITE});
        end
        vectors++;
        if (PADDR !== 32'h0 || PWDATA !== 32'h0) begin
            miscompares++; $display("FAIL reset_payload: got %h/%h want 0/0", PADDR, PWDATA);
        end
        vectors++;
        if (req_done !== 2'b00) begin
            miscompares++; $display("FAIL reset_done: got %b want 00", req_done);
        end
        next_cycle();
        PRESET = 1'b0;
    endtask

    task automatic test_single_read();
        req_valid = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h1000; PREADY = 1'b0;
        @(negedge PCLK);
        vectors++;
        if (PSEL !== 1'b0) begin miscompares++; $display("FAIL rd_idle_psel: got %b want 0", PSEL); end
        next_cycle();
        @(negedge PCLK);
        vectors++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 32'h1000 || PWRITE !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_setup: got sel=%b en=%b addr=%h wr=%b want 1 0 00001000 0", PSEL, PENABLE, PADDR, PWRITE);
        end
        next_cycle();
        PREADY = 1'b1; PRDATA = 32'hDEADBEEF;
        @(negedge PCLK);
        vectors++;
        if (PENABLE !== 1'b1 || req_done !== 2'b01 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_access: got en=%b done=%b rdata=%h err=%b want 1 01 deadbeef 0", PENABLE, req_done, rsp_rdata, rsp_err);
        end
        next_cycle();
        req_valid = 2'b00; PREADY = 1'b0;
        @(negedge PCLK);
        vectors++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || req_done !== 2'b00 || PADDR !== 32'h1000) begin
            miscompares++;
            $display("FAIL rd_after: got sel=%b en=%b done=%b addr=%h want 0 0 00 00001000", PSEL, PENABLE, req_done, PADDR);
        end
        next_cycle();
    endtask

    task automatic test_wait_states();
        req_valid = 2'b10; req_write = 2'b10; req_addr[63:32] = 32'h20; req_wdata[63:32] = 32'h5A5A;
        PREADY = 1'b0;
        @(negedge PCLK);
        next_cycle();
        // payload changes after the grant edge must not reach the bus
        req_addr[63:32] = 32'hFFFF0000; req_wdata[63:32] = 32'h1111; req_write = 2'b00;
        @(negedge PCLK);
        vectors++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 32'h20) begin
            miscompares++; $display("FAIL ws_setup: got sel=%b en=%b addr=%h want 1 0 00000020", PSEL, PENABLE, PADDR);
        end
        next_cycle();
        for (int a = 1; a <= 4; a++) begin
            PREADY = (a == 4);
            @(negedge PCLK);
            vectors++;
            if (PENABLE !== 1'b1 || PADDR !== 32'h20 || PWDATA !== 32'h5A5A || PWRITE !== 1'b1) begin
                miscompares++;
                $display("FAIL ws_stable[%0d]: got en=%b addr=%h wdata=%h wr=%b want 1 00000020 00005a5a 1", a, PENABLE, PADDR, PWDATA, PWRITE);
            end
            vectors++;
            if (req_done !== ((a == 4) ? 2'b10 : 2'b00) || rsp_err !== 1'b0) begin
                miscompares++; $display("FAIL ws_done[%0d]: got done=%b err=%b want %b 0", a, req_done, rsp_err, (a == 4) ? 2'b10 : 2'b00);
            end
            next_cycle();
        end
        req_valid = 2'b00; PREADY = 1'b0;
        @(negedge PCLK);
        vectors++;
        if (PSEL !== 1'b0) begin miscompares++; $display("FAIL ws_after_psel: got %b want 0", PSEL); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_done;
        logic [31:0] exp_addr;
        req_valid = 2'b11; req_write = 2'b00;
        req_addr[31:0] = 32'h100; req_addr[63:32] = 32'h200; PREADY = 1'b1; PRDATA = 32'h0;
        for (int c = 0; c < 12; c++) begin
            exp_done = (c % 3 != 2) ? 2'b00 : (((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
            exp_addr = ((c / 3) % 2 == 0) ? 32'h100 : 32'h200;
            @(negedge PCLK);
            vectors++;
            if (req_done !== exp_done || PSEL !== (c % 3 != 0)) begin
                miscompares++; $display("FAIL rr_cycle[%0d]: got done=%b sel=%b want %b %b", c, req_done, PSEL, exp_done, (c % 3 != 0));
            end
            if (c % 3 == 1) begin
                vectors++;
                if (PADDR !== exp_addr) begin
                    miscompares++; $display("FAIL rr_addr[%0d]: got %h want %h", c, PADDR, exp_addr);
                end
            end
            next_cycle();
        end
        req_valid = 2'b00; PREADY = 1'b0;
    endtask

    task automatic test_ready_on_timeout();
        req_valid = 2'b10; req_write = 2'b00; req_addr[63:32] = 32'h300; PREADY = 1'b0;
        @(negedge PCLK);
        next_cycle();
        @(negedge PCLK);
        next_cycle();
        for (int a = 1; a <= 4; a++) begin
            PREADY = (a == 4); PRDATA = 32'hCAFEF00D;
            @(negedge PCLK);
            vectors++;
            if (req_done !== ((a == 4) ? 2'b10 : 2'b00) || rsp_err !== 1'b0) begin
                miscompares++; $display("FAIL rto_done[%0d]: got done=%b err=%b want %b 0", a, req_done, rsp_err, (a == 4) ? 2'b10 : 2'b00);
            end
            if (a == 4) begin
                vectors++;
                if (rsp_rdata !== 32'hCAFEF00D) begin
                    miscompares++; $display("FAIL rto_rdata: got %h want cafef00d", rsp_rdata);
                end
            end
            next_cycle();
        end
        req_valid = 2'b00; PREADY = 1'b0;
        @(negedge PCLK);
        next_cycle();
    endtask

    task automatic test_timeout();
        req_valid = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h44; PREADY = 1'b0; PRDATA = 32'h12345678;
        @(negedge PCLK);
        next_cycle();
        @(negedge PCLK);
        next_cycle();
        for (int a = 1; a <= 4; a++) begin
            @(negedge PCLK);
            vectors++;
            if (req_done !== ((a == 4) ? 2'b01 : 2'b00) || rsp_err !== (a == 4)) begin
                miscompares++; $display("FAIL to_done[%0d]: got done=%b err=%b want %b %b", a, req_done, rsp_err, (a == 4) ? 2'b01 : 2'b00, (a == 4));
            end
            if (a == 4) begin
                vectors++;
                if (rsp_rdata !== 32'h0) begin
                    miscompares++; $display("FAIL to_rdata: got %h want 00000000", rsp_rdata);
                end
            end
            next_cycle();
        end
        req_valid = 2'b00;
        @(negedge PCLK);
        vectors++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || req_done !== 2'b00) begin
            miscompares++; $display("FAIL to_after: got sel=%b en=%b done=%b want 0 0 00", PSEL, PENABLE, req_done);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_access();
        req_valid = 2'b10; req_write = 2'b00; req_addr[63:32] = 32'h200; req_addr[31:0] = 32'h100; PREADY = 1'b0;
        @(negedge PCLK);
        next_cycle();
        @(negedge PCLK);
        next_cycle();
        PRESET = 1'b1;
        @(negedge PCLK);
        vectors++;
        if (req_done !== 2'b00) begin miscompares++; $display("FAIL rst_mid_done: got %b want 00", req_done); end
        next_cycle();
        PRESET = 1'b0; req_valid = 2'b11; PREADY = 1'b1; PRDATA = 32'h0BAD0BAD;
        @(negedge PCLK);
        vectors++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || req_done !== 2'b00) begin
            miscompares++; $display("FAIL rst_mid_after: got sel=%b en=%b done=%b want 0 0 00", PSEL, PENABLE, req_done);
        end
        next_cycle();
        @(negedge PCLK);
        vectors++;
        if (PADDR !== 32'h100) begin miscompares++; $display("FAIL rst_prio_addr: got %h want 00000100", PADDR); end
        next_cycle();
        @(negedge PCLK);
        vectors++;
        if (req_done !== 2'b01) begin miscompares++; $display("FAIL rst_prio_done: got %b want 01", req_done); end
        next_cycle();
        req_valid = 2'b00; PREADY = 1'b0;
    endtask

    initial begin
        PRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        PREADY = 1'b0; PRDATA = '0;
        test_reset();
        test_single_read();
        test_wait_states();
        test_round_robin();
        test_ready_on_timeout();
        test_timeout();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
